// File: rtl/nms_window_datapath.sv
// Non-maximum-suppression window datapath: fetches a 3x3 neighbourhood, then compares the centre against its gradient pair.
// Optional build macro NMS_BORDER_ZERO_EN zeroes results for centre pixels on the image border.
module nms_window_datapath #(
  parameter int IMG_W = 180,
  parameter int IMG_H = 120
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [14:0] refAddr,
  input  logic [3:0]  adjNumber,
  input  logic [3:0]  regAddr,
  input  logic        readen,
  input  logic [9:0]  memData,
  output logic [14:0] memAddr,
  output logic        memRd,
  output logic [7:0]  nmsOut,
  output logic        nmsValid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, COMPARE, OUTPUT} stateT;

  localparam logic [14:0] rowStep = 15'(IMG_W);

  stateT       state, nextState;
  logic [14:0] fetchOffset;
  logic [9:0]  win [9];
  logic        readenQ, armed, readenRise;
  logic [9:0]  pairA, pairB;
  logic [7:0]  centreMag;
  logic        keepCentre;

  // Offsets wrap modulo 2^15, matching a 16-bit signed sum truncated to 15 bits.
  always_comb begin
    fetchOffset = '0;
    case (adjNumber)
      4'd0: fetchOffset = -rowStep - 15'd1;
      4'd1: fetchOffset = -rowStep;
      4'd2: fetchOffset = -rowStep + 15'd1;
      4'd3: fetchOffset = -15'd1;
      4'd5: fetchOffset = 15'd1;
      4'd6: fetchOffset = rowStep - 15'd1;
      4'd7: fetchOffset = rowStep;
      4'd8: fetchOffset = rowStep + 15'd1;
      default: fetchOffset = '0;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      memAddr <= '0;
      memRd   <= 1'b0;
    end else if (adjNumber <= 4'd8) begin
      memAddr <= refAddr + fetchOffset;
      memRd   <= 1'b1;
    end else begin
      memRd   <= 1'b0;
    end
  end

  // An X or out-of-range slot matches no case item, so nothing is written.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      case (regAddr)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: win[regAddr] <= memData;
        default: ;
      endcase
    end
  end

  // armed stays low for the first edge after reset so a level already high is not seen as a rise.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      readenQ <= 1'b0;
      armed   <= 1'b0;
    end else begin
      readenQ <= readen;
      armed   <= 1'b1;
    end
  end

  assign readenRise = readen & ~readenQ & armed;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (readenRise) nextState = COMPARE;
      COMPARE: nextState = OUTPUT;
      OUTPUT:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    pairA = win[3];
    pairB = win[5];
    case (win[4][9:8])
      2'd1: begin pairA = win[2]; pairB = win[6]; end
      2'd2: begin pairA = win[1]; pairB = win[7]; end
      2'd3: begin pairA = win[0]; pairB = win[8]; end
      default: begin pairA = win[3]; pairB = win[5]; end
    endcase
  end

  assign centreMag  = win[4][7:0];
  assign keepCentre = (centreMag >= pairA[7:0]) && (centreMag > pairB[7:0]);

`ifdef NMS_BORDER_ZERO_EN
  logic onBorder, borderFlag;
  logic [14:0] colIndex;

  assign colIndex = refAddr % rowStep;
  assign onBorder = (refAddr < rowStep) || (refAddr >= 15'((IMG_H - 1) * IMG_W)) ||
                    (colIndex == 15'd0) || (colIndex == rowStep - 15'd1);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)                            borderFlag <= 1'b0;
    else if (state == IDLE && readenRise)   borderFlag <= onBorder;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)               nmsOut <= '0;
    else if (state == COMPARE) nmsOut <= (keepCentre && !borderFlag) ? centreMag : 8'd0;
  end
`else
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)               nmsOut <= '0;
    else if (state == COMPARE) nmsOut <= keepCentre ? centreMag : 8'd0;
  end
`endif

  assign nmsValid = (state == OUTPUT);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_nms_window_datapath.sv
// Scoreboard bench for nms_window_datapath: fetch addresses and NMS results are queued when driven, checked when produced.
module tb_nms_window_datapath;

  localparam int IMG_W = 180;
  localparam int IMG_H = 120;

  logic        clock = 1'b0;
  logic        nReset;
  logic [14:0] refAddr;
  logic [3:0]  adjNumber;
  logic [3:0]  regAddr;
  logic        readen;
  logic [9:0]  memData = '0;
  logic [14:0] memAddr;
  logic        memRd;
  logic [7:0]  nmsOut;
  logic        nmsValid;
  logic        busy;

  logic [9:0]  mem [32768];
  int          addrQ[$];
  int          nmsQ[$];
  int          checkCount = 0;
  int          errorCount = 0;
  int          pulseCount = 0;

  nms_window_datapath #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clock(clock), .nReset(nReset), .refAddr(refAddr), .adjNumber(adjNumber),
    .regAddr(regAddr), .readen(readen), .memData(memData), .memAddr(memAddr),
    .memRd(memRd), .nmsOut(nmsOut), .nmsValid(nmsValid), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (memRd) memData <= mem[memAddr];

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (nReset) begin
      if (memRd) begin
        if (addrQ.size() == 0) checkOutput("memRdSpurious", 1, 0);
        else                   checkOutput("memAddr", 32'(memAddr), addrQ.pop_front());
      end
      if (nmsValid) begin
        pulseCount++;
        if (nmsQ.size() == 0) checkOutput("nmsValidSpurious", 1, 0);
        else                  checkOutput("nmsOut", 32'(nmsOut), nmsQ.pop_front());
      end
    end
  end

  function automatic int addrOf(input int centre, input int k);
    return (centre + (k / 3 - 1) * IMG_W + (k % 3 - 1)) & 32'h7fff;
  endfunction

  function automatic int nmsModel(input logic [9:0] w [9]);
    int a, b;
    case (w[4][9:8])
      2'd0: begin a = 3; b = 5; end
      2'd1: begin a = 2; b = 6; end
      2'd2: begin a = 1; b = 7; end
      default: begin a = 0; b = 8; end
    endcase
    if (w[4][7:0] >= w[a][7:0] && w[4][7:0] > w[b][7:0]) return int'(w[4][7:0]);
    return 0;
  endfunction

  task automatic applyStimulus(input int centre, input logic [9:0] w [9]);
    for (int k = 0; k < 9; k++) mem[addrOf(centre, k)] = w[k];
    refAddr = 15'(centre);
    for (int i = 0; i < 11; i++) begin
      if (i < 9) begin
        adjNumber = 4'(i);
        addrQ.push_back(addrOf(centre, i));
      end else begin
        adjNumber = 4'd15;
      end
      regAddr = (i >= 2) ? 4'(i - 2) : 4'd15;
      @(posedge clock); #1;
    end
    regAddr = 4'd15;
    @(negedge clock);
    checkOutput("memRdIdle", 32'(memRd), 0);
    @(posedge clock); #1;
  endtask

  task automatic evaluate(input int expected);
    nmsQ.push_back(expected);
    readen = 1'b1;
    @(negedge clock);
    checkOutput("busyBefore", 32'(busy), 0);
    @(negedge clock);
    checkOutput("busyCompare", 32'(busy), 1);
    checkOutput("validCompare", 32'(nmsValid), 0);
    @(negedge clock);
    checkOutput("busyOutput", 32'(busy), 1);
    checkOutput("validOutput", 32'(nmsValid), 1);
    @(negedge clock);
    checkOutput("busyAfter", 32'(busy), 0);
    checkOutput("validAfter", 32'(nmsValid), 0);
    checkOutput("nmsHold", 32'(nmsOut), expected);
    @(posedge clock); #1;
    readen = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [9:0] w [9];
    int pulsesBefore;
    int borderExp;

    for (int i = 0; i < 32768; i++) mem[i] = '0;
    nReset = 1'b0; refAddr = '0; adjNumber = 4'd15; regAddr = 4'd15; readen = 1'b0;
    #12;
    checkOutput("rstMemAddr", 32'(memAddr), 0);
    checkOutput("rstMemRd", 32'(memRd), 0);
    checkOutput("rstNmsOut", 32'(nmsOut), 0);
    checkOutput("rstValid", 32'(nmsValid), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    @(posedge clock); #1;
    nReset = 1'b1;
    @(posedge clock); #1;

    // Local maximum along direction 0; fetch addresses around 1000 checked by the monitor.
    w = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd90, 10'd50, 10'd60, 10'd70, 10'd80};
    applyStimulus(1000, w);
    evaluate(90);

    // Direction 2: tie on pairA keeps the centre, tie on pairB suppresses it.
    w = '{10'd0, 10'd50, 10'd0, 10'd0, {2'd2, 8'd50}, 10'd0, 10'd0, 10'd40, 10'd0};
    applyStimulus(1000, w);
    evaluate(50);
    w[7] = 10'd50;
    applyStimulus(1000, w);
    evaluate(0);

    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 9; k++) w[k] = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 12))};
      applyStimulus(2000 + t * 500, w);
      evaluate(nmsModel(w));
    end

    // A second rise while busy must not start another evaluation.
    w = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd90, 10'd50, 10'd60, 10'd70, 10'd80};
    applyStimulus(1000, w);
    pulsesBefore = pulseCount;
    nmsQ.push_back(90);
    readen = 1'b1;
    @(posedge clock); #1;
    readen = 1'b0;
    @(posedge clock); #1;
    readen = 1'b1;
    repeat (5) begin @(posedge clock); #1; end
    checkOutput("singlePulse", pulseCount - pulsesBefore, 1);
    readen = 1'b0;
    @(posedge clock); #1;

    // Reset during COMPARE aborts; readen held high across release is not a rise.
    pulsesBefore = pulseCount;
    readen = 1'b1;
    @(posedge clock); #1;
    nReset = 1'b0;
    #1;
    checkOutput("midRstMemAddr", 32'(memAddr), 0);
    checkOutput("midRstMemRd", 32'(memRd), 0);
    checkOutput("midRstNmsOut", 32'(nmsOut), 0);
    checkOutput("midRstValid", 32'(nmsValid), 0);
    checkOutput("midRstBusy", 32'(busy), 0);
    @(posedge clock); #1;
    nReset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checkOutput("noBusyAfterRst", 32'(busy), 0);
    end
    checkOutput("noPulseAfterRst", pulseCount - pulsesBefore, 0);
    @(posedge clock); #1;
    readen = 1'b0;
    @(posedge clock); #1;
    evaluate(0);

    // Centre on row 0.
    w = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd200, 10'd5, 10'd6, 10'd7, 10'd8};
    applyStimulus(5, w);
`ifdef NMS_BORDER_ZERO_EN
    borderExp = 0;
`else
    borderExp = 200;
`endif
    evaluate(borderExp);

    checkOutput("addrQEmpty", addrQ.size(), 0);
    checkOutput("nmsQEmpty", nmsQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/nms_window_datapath.md
NMS_WINDOW_DATAPATH -- requirements
Module: nms_window_datapath

Interface
REQ-001 SHALL have parameter IMG_W, default 180, image width in pixels (row pitch of the magnitude memory).
REQ-002 SHALL have parameter IMG_H, default 120, image height in rows.
REQ-003 SHALL have port clock  input  1  rising-edge system clock.
REQ-004 SHALL have port nReset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port refAddr  input  15  linear address of the centre pixel (row*IMG_W+col).
REQ-006 SHALL have port adjNumber  input  4  neighbour index 0..8 to fetch, row-major (4 = centre); any other value = no fetch.
REQ-007 SHALL have port regAddr  input  4  window-register slot 0..8 to load from memData; any other value, including X, = no write.
REQ-008 SHALL have port readen  input  1  compute request; its 0->1 transition starts one NMS evaluation.
REQ-009 SHALL have port memData  input  10  read data {dir[9:8], mag[7:0]}, valid 1 cycle after memRd.
REQ-010 SHALL have port memAddr  output  15  registered memory read address.
REQ-011 SHALL have port memRd  output  1  registered memory read strobe.
REQ-012 SHALL have port nmsOut  output  8  suppressed magnitude of the centre pixel.
REQ-013 SHALL have port nmsValid  output  1  one-cycle pulse qualifying nmsOut.
REQ-014 SHALL have port busy  output  1  high while an evaluation is in progress.

Function
REQ-015 SHALL, for adjNumber=k (0..8) in cycle t, drive memAddr = refAddr + (k/3-1)*IMG_W + (k%3-1), computed 16-bit signed and truncated to 15 bits, with memRd=1 in cycle t+1.
REQ-016 SHALL drive memRd=0 in cycle t+1 and hold memAddr when adjNumber>8 in cycle t.
REQ-017 SHALL, in any cycle with regAddr=j (0..8), write memData into window slot W[j] at that cycle's rising edge; the fetch-to-write latency is 2 cycles (adjNumber=k at t pairs with regAddr=k at t+2).
REQ-018 SHALL register readen and detect its rising edge; the level of readen has no other effect.
REQ-019 SHALL implement FSM IDLE -> COMPARE -> OUTPUT -> IDLE: the readen rise moves IDLE->COMPARE; COMPARE and OUTPUT each last exactly one cycle.
REQ-020 SHALL, in COMPARE, select the neighbour pair by centre direction W[4].dir: 0 -> (3,5); 1 -> (2,6); 2 -> (1,7); 3 -> (0,8).
REQ-021 SHALL register nmsOut = W[4].mag when W[4].mag >= pairA.mag AND W[4].mag > pairB.mag, else 8'd0 (unsigned compare).
REQ-022 SHALL assert nmsValid for exactly the OUTPUT cycle, i.e. 2 cycles after the cycle in which readen is first sampled high; nmsOut SHALL hold its value until the next OUTPUT.
REQ-023 SHALL assert busy in COMPARE and OUTPUT only.
REQ-024 SHALL ignore readen rises while busy=1 (no queuing).
REQ-025 SHALL keep serving fetches and window writes in every state; a write to W[j] during COMPARE is seen by the comparison only if it occurs before that cycle's edge.

Reset
REQ-026 SHALL, on nReset=0, immediately set memAddr=0, memRd=0, nmsOut=0, nmsValid=0, busy=0, all W[0..8]=0, registered readen=0, FSM=IDLE.
REQ-027 SHALL abort an evaluation in progress on reset mid-operation, with no nmsValid pulse.
REQ-028 SHALL treat readen already high at reset release as no rise; a new 0->1 transition is required.

Configuration
REQ-029 SHALL, with macro NMS_BORDER_ZERO_EN defined, force nmsOut=0 when refAddr lies on row 0, row IMG_H-1, column 0 or column IMG_W-1 (with the border flag latched at the readen rise); timing per REQ-022 is unchanged.
REQ-030 SHALL, without NMS_BORDER_ZERO_EN, apply no border handling: neighbour addresses wrap per REQ-015 and the comparison runs normally.

Verification
REQ-031 Fetch: refAddr=1000, adjNumber 0..8 on consecutive cycles -> memAddr 819,820,821,999,1000,1001,1179,1180,1181 from cycle t+1, memRd=1 each cycle; then adjNumber=15 -> memRd=0.
REQ-032 Maximum: W mags 10,20,30,40,90,50,60,70,80 with dir=0, readen rise -> nmsValid pulse 2 cycles later, nmsOut=90, busy high 2 cycles.
REQ-033 Suppressed and tie: dir=2, centre 50, W1=50, W7=40 -> nmsOut=50; then W7=50 -> nmsOut=0.
REQ-034 Busy and reset: readen toggled during COMPARE -> single nmsValid; nReset pulsed during COMPARE -> no nmsValid, all outputs 0.
REQ-035 Border: refAddr=5 (row 0), centre max, readen rise -> nmsOut=0 with NMS_BORDER_ZERO_EN defined, nmsOut=centre mag without it.
